// File: rtl/bist_result_reader.sv
// JTAG-readable BIST results log: mismatch records are queued during RUNBIST
// and drained one record per Capture-DR under READBIST, shifted out LSB-first.
module bist_result_reader #(
   parameter int ADDR_W      = 8,
   parameter int LOG_DEPTH_W = 3
) (
   input  logic              clk,
   input  logic              TLR,
   input  logic              RUNBIST_SELECT,
   input  logic              READBIST_SELECT,
   input  logic              CAPTUREDR,
   input  logic              SHIFTDR,
   input  logic              UPDATEDR,
   input  logic              TDI,
   output logic              TDO,
   input  logic              ERR_VALID,
   input  logic [ADDR_W-1:0] ERR_PC,
   input  logic [3:0]        ERR_DATA,
   input  logic              BIST_DONE
);

   localparam int DR_W  = ADDR_W + 16;
   localparam int REC_W = ADDR_W + 4;
   localparam int DEPTH = 1 << LOG_DEPTH_W;
   localparam logic [LOG_DEPTH_W:0]   FULL_CNT = (LOG_DEPTH_W+1)'(DEPTH);
   localparam logic [LOG_DEPTH_W:0]   CNT_ONE  = (LOG_DEPTH_W+1)'(1);
   localparam logic [LOG_DEPTH_W-1:0] PTR_ONE  = LOG_DEPTH_W'(1);

   logic                   run_q;
   logic [REC_W-1:0]       fifo_mem [DEPTH];
   logic [LOG_DEPTH_W-1:0] rd_ptr;
   logic [LOG_DEPTH_W-1:0] wr_ptr;
   logic [LOG_DEPTH_W:0]   count;
   logic                   ovf;
   logic                   done;
   logic [7:0]             err_cnt;
   logic [DR_W-1:0]        sr;

   logic             run_start;
   logic             log_en;
   logic             cap;
   logic             shift;
   logic             empty;
   logic             full;
   logic             pop;
   logic             push_req;
   logic             push;
   logic             upd_clear;
   logic             clear;
   logic [REC_W-1:0] head_rec;

   always_comb begin
      run_start = RUNBIST_SELECT & ~run_q;
      log_en    = RUNBIST_SELECT & ~run_start;
      cap       = READBIST_SELECT & CAPTUREDR;
      shift     = READBIST_SELECT & SHIFTDR & ~CAPTUREDR;
      empty     = (count == '0);
      full      = (count == FULL_CNT);
      pop       = cap & ~empty;
      push_req  = log_en & ERR_VALID;
      // A full FIFO still accepts a record when the head leaves the same cycle.
      push      = push_req & (~full | pop);
      upd_clear = READBIST_SELECT & UPDATEDR & sr[DR_W-1] & ~RUNBIST_SELECT;
      clear     = run_start | upd_clear;
      head_rec  = empty ? '0 : fifo_mem[rd_ptr];
   end

   assign TDO = READBIST_SELECT ? sr[0] : 1'b0;

   always_ff @(posedge clk) begin
      if (!TLR && !clear && push) begin
         fifo_mem[wr_ptr] <= {ERR_DATA, ERR_PC};
      end
   end

   always_ff @(posedge clk) begin
      if (TLR) begin
         run_q   <= 1'b0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         done    <= 1'b0;
         err_cnt <= '0;
         sr      <= '0;
      end else begin
         run_q <= RUNBIST_SELECT;
         if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            err_cnt <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
            if (push_req && full && !pop) ovf <= 1'b1;
            if (push_req && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (BIST_DONE && RUNBIST_SELECT) done <= 1'b1;
         end
         // Status fields are the pre-update values; the head record is popped here.
         if (cap) begin
            sr <= {~empty, ovf, done, 1'b0, err_cnt, head_rec};
         end else if (shift) begin
            sr <= {TDI, sr[DR_W-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_bist_result_reader.sv
// Directed-plus-random bench for bist_result_reader against a queue-based
// model of the results log.
module tb_bist_result_reader;

   logic       clk = 1'b0;
   logic       tlr = 1'b1;
   logic       runbist = 1'b0;
   logic       readbist = 1'b0;
   logic       capturedr = 1'b0;
   logic       shiftdr = 1'b0;
   logic       updatedr = 1'b0;
   logic       tdi = 1'b0;
   logic       tdo;
   logic       err_valid = 1'b0;
   logic [7:0] err_pc = '0;
   logic [3:0] err_data = '0;
   logic       bist_done = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [11:0] mq[$];
   bit          m_ovf = 0;
   bit          m_done = 0;
   int          m_cnt = 0;
   bit          m_sr_msb = 0;

   bist_result_reader dut (
      .clk(clk), .TLR(tlr), .RUNBIST_SELECT(runbist), .READBIST_SELECT(readbist),
      .CAPTUREDR(capturedr), .SHIFTDR(shiftdr), .UPDATEDR(updatedr), .TDI(tdi),
      .TDO(tdo), .ERR_VALID(err_valid), .ERR_PC(err_pc), .ERR_DATA(err_data),
      .BIST_DONE(bist_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_ovf  = 0;
      m_done = 0;
      m_cnt  = 0;
   endtask

   function automatic logic [23:0] model_capture();
      logic [11:0] rec;
      bit v;
      v   = (mq.size() != 0);
      rec = v ? mq.pop_front() : 12'h000;
      return {v, m_ovf, m_done, 1'b0, 8'(m_cnt), rec};
   endfunction

   task automatic log_err(input logic [7:0] pc, input logic [3:0] data);
      err_valid = 1'b1;
      err_pc    = pc;
      err_data  = data;
      tick();
      err_valid = 1'b0;
      if (runbist) begin
         if (m_cnt < 255) m_cnt++;
         if (mq.size() < 8) mq.push_back({data, pc});
         else m_ovf = 1;
      end
   endtask

   task automatic run_edge(input bit with_err);
      runbist   = 1'b1;
      err_valid = with_err;
      err_pc    = 8'($urandom_range(0, 255));
      err_data  = 4'($urandom_range(0, 15));
      tick();
      err_valid = 1'b0;
      model_clear();
   endtask

   task automatic done_pulse();
      bist_done = 1'b1;
      tick();
      bist_done = 1'b0;
      if (runbist) m_done = 1;
   endtask

   task automatic update_pulse();
      readbist = 1'b1;
      updatedr = 1'b1;
      tick();
      updatedr = 1'b0;
      if (m_sr_msb && !runbist) model_clear();
   endtask

   task automatic read_check(input string tag, input logic tdi_v, output logic [23:0] got);
      logic [23:0] exp;
      exp       = model_capture();
      readbist  = 1'b1;
      capturedr = 1'b1;
      tick();
      capturedr = 1'b0;
      shiftdr   = 1'b1;
      tdi       = tdi_v;
      for (int i = 0; i < 24; i++) begin
         got[i] = tdo;
         tick();
      end
      shiftdr  = 1'b0;
      tdi      = 1'b0;
      m_sr_msb = tdi_v;
      chk(tag, {8'h00, got}, {8'h00, exp});
   endtask

   initial begin
      logic [23:0] w;
      logic [23:0] exp;
      int n;

      // Reset state
      tick(); tick();
      tlr = 1'b0;
      readbist = 1'b1;
      #1;
      chk("reset_tdo", {31'd0, tdo}, 32'd0);
      read_check("reset_word", 1'b0, w);

      // 1. Basic read
      readbist = 1'b0;
      run_edge(0);
      log_err(8'h05, 4'hA);
      done_pulse();
      read_check("basic_word", 1'b0, w);
      chk("basic_const", {8'h00, w}, 32'h00A01A05);
      read_check("basic_second", 1'b0, w);
      chk("basic_second_valid", {31'd0, w[23]}, 32'd0);

      // 2. Overflow
      runbist = 1'b0;
      tick();
      run_edge(0);
      for (int i = 1; i <= 10; i++) log_err(8'(i), 4'($urandom_range(0, 15)));
      for (int i = 1; i <= 9; i++) begin
         read_check($sformatf("ovf_read%0d", i), 1'b0, w);
         if (i == 1) chk("ovf_first_pc", {24'd0, w[7:0]}, 32'd1);
      end
      chk("ovf_ninth_valid", {31'd0, w[23]}, 32'd0);

      // 3. Saturation
      runbist = 1'b0;
      tick();
      run_edge(0);
      for (int i = 0; i < 300; i++) log_err(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      read_check("sat_word", 1'b0, w);
      chk("sat_cnt", {24'd0, w[19:12]}, 32'hFF);
      chk("sat_ovf", {31'd0, w[22]}, 32'd1);

      // Random rounds while the run stays active
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++) begin
            log_err(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) tick();
         end
         if ($urandom_range(0, 1) == 1) done_pulse();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) read_check($sformatf("rand_r%0d_%0d", r, i), 1'b0, w);
      end

      // 4. Run restart with ERR_VALID on the edge cycle
      runbist = 1'b0;
      tick();
      run_edge(0);
      for (int i = 0; i < 3; i++) log_err(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      done_pulse();
      runbist = 1'b0;
      tick();
      run_edge(1);
      read_check("restart_word", 1'b0, w);
      chk("restart_const", {8'h00, w}, 32'h0);

      // 5a. Clear command with RUNBIST low
      for (int i = 0; i < 3; i++) log_err(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      runbist = 1'b0;
      tick();
      read_check("clr_load", 1'b1, w);
      update_pulse();
      read_check("clr_after", 1'b0, w);
      chk("clr_after_const", {8'h00, w}, 32'h0);

      // 5b. Clear command ignored while RUNBIST is high
      run_edge(0);
      for (int i = 0; i < 3; i++) log_err(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      read_check("noclr_load", 1'b1, w);
      update_pulse();
      read_check("noclr_after1", 1'b0, w);
      chk("noclr_valid", {31'd0, w[23]}, 32'd1);
      chk("noclr_cnt", {24'd0, w[19:12]}, 32'd3);
      read_check("noclr_after2", 1'b0, w);

      // 6. Reset mid-shift, then TDO gating
      log_err(8'h33, 4'h5);
      runbist = 1'b0;
      tick();
      exp = model_capture();
      readbist  = 1'b1;
      capturedr = 1'b1;
      tick();
      capturedr = 1'b0;
      shiftdr   = 1'b1;
      for (int i = 0; i < 7; i++) begin
         w[i] = tdo;
         tick();
      end
      shiftdr = 1'b0;
      chk("midshift_bits", {25'd0, w[6:0]}, {25'd0, exp[6:0]});
      tlr = 1'b1;
      tick();
      tlr = 1'b0;
      model_clear();
      chk("tlr_tdo", {31'd0, tdo}, 32'd0);
      read_check("tlr_word", 1'b0, w);

      run_edge(0);
      log_err(8'h81, 4'hC);
      read_check("gate_word", 1'b0, w);
      runbist = 1'b0;
      tick();
      run_edge(0);
      log_err(8'h47, 4'h3);
      capturedr = 1'b1;
      tick();
      capturedr = 1'b0;
      chk("gate_tdo_on", {31'd0, tdo}, 32'd1);
      readbist = 1'b0;
      #1;
      chk("gate_tdo_off", {31'd0, tdo}, 32'd0);
      shiftdr = 1'b1;
      tick();
      shiftdr = 1'b0;
      chk("gate_tdo_off_shift", {31'd0, tdo}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
